// File: rtl/conv_kernel_sched_if.sv
// Signal bundle between the 3x3 conv scheduler and its neighbours:
// pass control, window requests, kernel strobe, result writes and credit returns.
interface conv_kernel_sched_if #(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [DIM_W-1:0]  cfg_w;
  logic [DIM_W-1:0]  cfg_h;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              req_valid;
  logic              req_ready;
  logic [DIM_W-1:0]  req_row;
  logic [DIM_W-1:0]  req_col;
  logic              k_in_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              cred_ret;

  modport master (
    input  start, cfg_w, cfg_h, req_ready, k_in_valid, cred_ret,
    output busy, done, cfg_err, req_valid, req_row, req_col, wr_en, wr_addr, wr_last
  );

  modport slave (
    output start, cfg_w, cfg_h, req_ready, k_in_valid, cred_ret,
    input  busy, done, cfg_err, req_valid, req_row, req_col, wr_en, wr_addr, wr_last
  );
endinterface

// File: rtl/conv_kernel_sched.sv
// Raster-walks valid 3x3 window positions, issues fetch requests, times result writes KLAT cycles after k_in_valid.
// Requests stall on req_ready low or zero credit; the result path never stalls.
module conv_kernel_sched #(
  parameter int KLAT   = 5,
  parameter int CRED   = 8,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  conv_kernel_sched_if.master bus
);
  localparam int            CW        = $clog2(CRED + 1);
  localparam int            PW        = 2 * DIM_W;
  localparam logic [CW-1:0] CRED_FULL = CW'(CRED);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } pos_t;

  state_t            state;
  state_t            state_nxt;
  pos_t              pos;
  logic [DIM_W-1:0]  col_last_q;
  logic [DIM_W-1:0]  row_last_q;
  logic [ADDR_W-1:0] n_last_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              err_q;
  logic [CW-1:0]     credit;
  logic [KLAT-1:0]   lat_pipe;

  logic              start_ok;
  logic              cfg_bad;
  logic              req_vld;
  logic              hs;
  logic              col_end;
  logic              row_end;
  logic              wr_vld;
  logic              wr_fin;
  logic [PW-1:0]     n_outs;

  assign start_ok = (state == IDLE) && bus.start;
  assign cfg_bad  = (bus.cfg_w < DIM_W'(3)) || (bus.cfg_h < DIM_W'(3));
  assign n_outs   = {{DIM_W{1'b0}}, bus.cfg_w - DIM_W'(2)} * {{DIM_W{1'b0}}, bus.cfg_h - DIM_W'(2)};
  assign req_vld  = (state == RUN) && (credit != '0);
  assign hs       = req_vld && bus.req_ready;
  assign col_end  = (pos.col == col_last_q);
  assign row_end  = (pos.row == row_last_q);
  assign wr_vld   = lat_pipe[KLAT-1];
  assign wr_fin   = wr_vld && (wr_addr_q == n_last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = cfg_bad ? DONE : RUN;
      RUN:     if (hs && row_end && col_end) state_nxt = DRAIN;
      DRAIN:   if (wr_fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos        <= '0;
      col_last_q <= '0;
      row_last_q <= '0;
      n_last_q   <= '0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      lat_pipe   <= '0;
      credit     <= CRED_FULL;
    end else begin
      // Kernel pipeline cannot stall, so every strobe simply ages KLAT cycles.
      lat_pipe[0] <= bus.k_in_valid;
      for (int i = 1; i < KLAT; i++) begin
        lat_pipe[i] <= lat_pipe[i-1];
      end

      if (start_ok) begin
        col_last_q <= bus.cfg_w - DIM_W'(3);
        row_last_q <= bus.cfg_h - DIM_W'(3);
        n_last_q   <= ADDR_W'(n_outs - PW'(1));
        err_q      <= cfg_bad;
        pos        <= '0;
        wr_addr_q  <= '0;
      end else begin
        if (hs) begin
          if (col_end) begin
            pos.col <= '0;
            pos.row <= pos.row + DIM_W'(1);
          end else begin
            pos.col <= pos.col + DIM_W'(1);
          end
        end
        if (wr_vld) begin
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
      end

      // A return that lands with a handshake cancels it; returns beyond full are dropped.
      if (hs && !bus.cred_ret) begin
        credit <= credit - CW'(1);
      end else if (!hs && bus.cred_ret && (credit != CRED_FULL)) begin
        credit <= credit + CW'(1);
      end
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.cfg_err   = (state == DONE) && err_q;
    bus.req_valid = req_vld;
    bus.req_row   = pos.row;
    bus.req_col   = pos.col;
    bus.wr_en     = wr_vld;
    bus.wr_addr   = wr_addr_q;
    bus.wr_last   = wr_fin;
  end
endmodule

// File: tb/tb_conv_kernel_sched.sv
// Bench for conv_kernel_sched: responder models fetch/credit return, reference lists built from raster rules.
module tb_conv_kernel_sched;
  localparam int KLAT   = 5;
  localparam int CRED   = 4;
  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;
  localparam int FD     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_kernel_sched_if #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  conv_kernel_sched #(.KLAT(KLAT), .CRED(CRED), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0, k_sent = 0, wr_tot = 0, owed = 0;
  int   done_cnt = 0, err_cnt = 0, done_cyc = -1, last_cyc = -100, stab_err = 0;
  int   obs_req[$];
  int   obs_wr[$];
  int   prev_pos = 0;
  bit   prev_stall = 1'b0;
  bit   ret_auto = 1'b0;
  bit   ret_man = 1'b0;
  bit   hs_s, ret_s;
  logic [7:0] fsr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_pat(input int mode, input int k);
    case (mode)
      1:       return (k % 3) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b1;
    endcase
  endfunction

  task automatic clear_obs();
    obs_req.delete();
    obs_wr.delete();
    done_cnt = 0;
    err_cnt  = 0;
    done_cyc = -1;
    last_cyc = -100;
    stab_err = 0;
  endtask

  // Environment: fetch unit answers FD cycles after a handshake; downstream repays owed credits.
  initial begin
    bus.k_in_valid = 1'b0;
    bus.cred_ret   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        fsr            = '0;
        owed           = 0;
        prev_stall     = 1'b0;
        bus.k_in_valid = 1'b0;
        bus.cred_ret   = 1'b0;
      end else begin
        hs_s = bus.req_valid && bus.req_ready;
        if (prev_stall && ((int'(bus.req_row) * 256 + int'(bus.req_col)) != prev_pos)) stab_err++;
        prev_stall = bus.req_valid && !bus.req_ready;
        prev_pos   = int'(bus.req_row) * 256 + int'(bus.req_col);
        if (hs_s) obs_req.push_back(prev_pos);
        fsr = {fsr[6:0], hs_s};
        bus.k_in_valid = fsr[FD-1];
        if (fsr[FD-1]) k_sent++;
        if (bus.wr_en) begin
          obs_wr.push_back((bus.wr_last ? 65536 : 0) + int'(bus.wr_addr));
          wr_tot++;
          if (bus.wr_last) last_cyc = cyc;
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
          if (bus.cfg_err) err_cnt++;
        end
        ret_s = ret_man || (ret_auto && owed > 0);
        if (ret_s && owed > 0) owed--;
        if (bus.wr_en) owed++;
        bus.cred_ret = ret_s;
      end
    end
  end

  task automatic start_pass(input int w, input int h);
    clear_obs();
    tick();
    bus.cfg_w = DIM_W'(w);
    bus.cfg_h = DIM_W'(h);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cfg_w = DIM_W'($urandom_range(0, 255));
    bus.cfg_h = DIM_W'($urandom_range(0, 255));
    check("busy_t1", 32'(bus.busy), 1);
    check("req_valid_t1", 32'(bus.req_valid), 1);
  endtask

  task automatic wait_done(input int mode, input int budget);
    bit got = 1'b0;
    for (int k = 1; k <= budget && !got; k++) begin
      tick();
      bus.req_ready = rdy_pat(mode, k);
      got = bus.done;
    end
    check("done_seen", 32'(got), 1);
    tick();
    bus.req_ready = 1'b1;
    check("busy_drop", 32'(bus.busy), 0);
    check("done_one_cycle", 32'(bus.done), 0);
  endtask

  task automatic compare_pass(input int w, input int h);
    int n = (w - 2) * (h - 2);
    int k = 0;
    check("req_count", obs_req.size(), n);
    for (int r = 0; r < h - 2; r++) begin
      for (int c = 0; c < w - 2; c++) begin
        if (k < obs_req.size()) check("req_pos", obs_req[k], r * 256 + c);
        k++;
      end
    end
    check("wr_count", obs_wr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < obs_wr.size()) check("wr_addr_last", obs_wr[i], ((i == n - 1) ? 65536 : 0) + i);
    end
    check("done_after_last", done_cyc, last_cyc + 1);
    check("done_count", done_cnt, 1);
    check("cfg_err_count", err_cnt, 0);
    check("req_hold_stall", stab_err, 0);
  endtask

  initial begin
    int w, h;
    bit got;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.cfg_w     = '0;
    bus.cfg_h     = '0;
    bus.req_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_cfg_err", 32'(bus.cfg_err), 0);
    check("rst_req_valid", 32'(bus.req_valid), 0);
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_wr_last", 32'(bus.wr_last), 0);
    check("rst_req_row", 32'(bus.req_row), 0);
    check("rst_req_col", 32'(bus.req_col), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);

    // Basic 5x5 pass
    ret_auto = 1'b1;
    bus.req_ready = 1'b1;
    start_pass(5, 5);
    wait_done(0, 500);
    compare_pass(5, 5);

    // Reset in the middle of a pass with results in flight
    start_pass(8, 8);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      tick();
      got = (k_sent - wr_tot) >= 3;
    end
    check("inflight_reached", 32'(got), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_req_valid", 32'(bus.req_valid), 0);
    check("mid_rst_wr_en", 32'(bus.wr_en), 0);
    check("mid_rst_req_pos", 32'({bus.req_row, bus.req_col}), 0);
    check("mid_rst_wr_addr", 32'(bus.wr_addr), 0);
    clear_obs();
    repeat (12) tick();
    check("no_wr_after_rst", obs_wr.size(), 0);
    check("no_req_after_rst", obs_req.size(), 0);
    start_pass(3, 3);
    wait_done(0, 200);
    compare_pass(3, 3);

    // Surplus returns while idle must not raise credit above full
    ret_man = 1'b1;
    repeat (3) tick();
    ret_man = 1'b0;
    repeat (2) tick();

    // Credit stall: 4x6 with no returns until cycle 20
    ret_auto = 1'b0;
    start_pass(4, 6);
    repeat (19) tick();
    check("stall_hs_count", obs_req.size(), CRED);
    check("stall_req_valid", 32'(bus.req_valid), 0);
    ret_man = 1'b1;
    tick();
    check("stall_resume", 32'(bus.req_valid), 1);
    repeat (CRED - 1) tick();
    ret_man  = 1'b0;
    ret_auto = 1'b1;
    wait_done(0, 500);
    compare_pass(4, 6);

    // Handshake and return together at credit 1; stray start during RUN
    ret_auto = 1'b0;
    start_pass(6, 6);
    repeat (20) tick();
    check("sim_stalled", 32'(bus.req_valid), 0);
    bus.req_ready = 1'b0;
    ret_man = 1'b1;
    tick();
    ret_man = 1'b0;
    check("sim_credit_one", 32'(bus.req_valid), 1);
    bus.req_ready = 1'b1;
    ret_man = 1'b1;
    tick();
    bus.req_ready = 1'b0;
    ret_man = 1'b0;
    check("sim_keep_valid", 32'(bus.req_valid), 1);
    bus.cfg_w = DIM_W'(3);
    bus.cfg_h = DIM_W'(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("sim_keep_valid2", 32'(bus.req_valid), 1);
    check("sim_hs_count", obs_req.size(), CRED + 1);
    ret_auto = 1'b1;
    wait_done(0, 500);
    compare_pass(6, 6);
    repeat (5) tick();
    check("start_not_queued", 32'(bus.busy), 0);

    // Configuration error
    clear_obs();
    tick();
    bus.cfg_w = DIM_W'(2);
    bus.cfg_h = DIM_W'(7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("err_done", 32'(bus.done), 1);
    check("err_cfg_err", 32'(bus.cfg_err), 1);
    check("err_req_valid", 32'(bus.req_valid), 0);
    tick();
    check("err_done_drop", 32'(bus.done), 0);
    check("err_busy_drop", 32'(bus.busy), 0);
    repeat (10) tick();
    check("err_no_req", obs_req.size(), 0);
    check("err_no_wr", obs_wr.size(), 0);

    // Random sizes under steady, 1-0-0 and random backpressure
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(3, 7);
      h = $urandom_range(3, 7);
      bus.req_ready = 1'b1;
      start_pass(w, h);
      wait_done(i % 3, 1500);
      compare_pass(w, h);
      repeat (2) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
